// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_core
//  Purpose  : 16x-oversampled UART receiver, 8 data bits LSB-first, with
//             majority-vote bit decisions and start/stop/parity validation.
//             Optional even-parity bit enabled by macro UART_RX_PARITY_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_core #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       SYS_CLK,
    input  logic       RST,
    input  logic       rxd,
    output logic       rx_busy,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       frame_err,
    output logic       parity_err
);

    localparam int c_div = CLK_FREQ / (BAUD_RATE * 16);
    localparam int c_tw  = (c_div > 1) ? $clog2(c_div) : 1;
    localparam logic [c_tw-1:0] c_tick_max = c_tw'(c_div - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY    = 3'd3,
`endif
        S_STOP      = 3'd4,
        S_WAIT_IDLE = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_sync1;
    logic              r_sync2;
    logic              w_rxs;
    logic [c_tw-1:0]   r_tick_cnt;
    logic              w_tick;
    logic [3:0]        r_os_cnt;
    logic              r_s7;
    logic              r_s8;
    logic              w_decide;
    logic              w_bit;
    logic [2:0]        r_bit_cnt;
    logic [7:0]        r_shift;
    logic              w_par_mismatch;
    logic              w_start_det;
    logic              w_start_ok;
    logic              w_data_bit;
    logic              w_par_bit;
    logic              w_stop_good;
    logic              w_stop_ferr;
    logic              w_stop_perr;

    always_ff @(posedge SYS_CLK or posedge RST) begin
        if (RST) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rxs    = r_sync2;
    assign w_tick   = (r_tick_cnt == c_tick_max);
    assign w_decide = w_tick && (r_os_cnt == 4'd9);
    // Vote over the three centre oversamples; the third is the live sample.
    assign w_bit    = (r_s7 & r_s8) | (r_s7 & w_rxs) | (r_s8 & w_rxs);

    always_ff @(posedge SYS_CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start_det  = 1'b0;
        w_start_ok   = 1'b0;
        w_data_bit   = 1'b0;
        w_par_bit    = 1'b0;
        w_stop_good  = 1'b0;
        w_stop_ferr  = 1'b0;
        w_stop_perr  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_rxs) begin
                    w_start_det  = 1'b1;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (w_decide) begin
                    if (!w_bit) begin
                        w_start_ok   = 1'b1;
                        w_state_next = S_DATA;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (w_decide) begin
                    w_data_bit = 1'b1;
                    if (r_bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_next = S_PARITY;
`else
                        w_state_next = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (w_decide) begin
                    w_par_bit    = 1'b1;
                    w_state_next = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (w_decide) begin
                    if (!w_bit) begin
                        w_stop_ferr  = 1'b1;
                        w_state_next = S_WAIT_IDLE;
                    end else if (w_par_mismatch) begin
                        w_stop_perr  = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_stop_good  = 1'b1;
                        w_state_next = S_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (w_rxs) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge SYS_CLK or posedge RST) begin
        if (RST) begin
            r_tick_cnt <= '0;
            r_os_cnt   <= 4'd0;
            r_s7       <= 1'b1;
            r_s8       <= 1'b1;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'h00;
            rx_busy    <= 1'b0;
            rx_data    <= 8'h00;
            rx_done    <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            // Start detect re-phases the oversample grid onto the falling edge.
            if (w_start_det) begin
                r_tick_cnt <= '0;
                r_os_cnt   <= 4'd0;
            end else begin
                r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
                if (w_tick) begin
                    r_os_cnt <= r_os_cnt + 4'd1;
                end
            end
            if (w_tick && (r_os_cnt == 4'd7)) begin
                r_s7 <= w_rxs;
            end
            if (w_tick && (r_os_cnt == 4'd8)) begin
                r_s8 <= w_rxs;
            end
            if (w_start_ok) begin
                rx_busy   <= 1'b1;
                frame_err <= 1'b0;
                r_bit_cnt <= 3'd0;
            end
            if (w_data_bit) begin
                r_shift[r_bit_cnt] <= w_bit;
                r_bit_cnt          <= r_bit_cnt + 3'd1;
            end
            if (w_stop_good) begin
                rx_busy <= 1'b0;
                rx_data <= r_shift;
                rx_done <= 1'b1;
            end
            if (w_stop_ferr) begin
                rx_busy   <= 1'b0;
                frame_err <= 1'b1;
            end
            if (w_stop_perr) begin
                rx_busy <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic r_par_mismatch;
    logic r_parity_err;

    always_ff @(posedge SYS_CLK or posedge RST) begin
        if (RST) begin
            r_par_mismatch <= 1'b0;
            r_parity_err   <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_par_mismatch <= 1'b0;
                r_parity_err   <= 1'b0;
            end
            // Even parity: received bit must equal the XOR of the data bits.
            if (w_par_bit) begin
                r_par_mismatch <= w_bit ^ (^r_shift);
            end
            if (w_stop_perr) begin
                r_parity_err <= 1'b1;
            end
        end
    end

    assign w_par_mismatch = r_par_mismatch;
    assign parity_err     = r_parity_err;
`else
    assign w_par_mismatch = 1'b0;
    assign parity_err     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_core
//  Purpose  : Scoreboard bench for uart_rx_core at DIV=2 (32 clocks per bit).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_core;

    localparam int c_bit = 32;
`ifdef UART_RX_PARITY_EN
    localparam int c_busy_len = 320;
`else
    localparam int c_busy_len = 288;
`endif

    typedef struct {
        logic [7:0] data;
        logic       done;
        logic       ferr;
        logic       perr;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       rxd;
    logic       rx_busy;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       frame_err;
    logic       parity_err;

    exp_t exp_q[$];
    int   n_checks;
    int   n_errors;
    int   n_good;
    int   done_cnt;
    int   busy_len;
    logic prev_busy;

    uart_rx_core #(
        .CLK_FREQ  (32_000_000),
        .BAUD_RATE (1_000_000)
    ) u_dut (
        .SYS_CLK    (clk),
        .RST        (rst),
        .rxd        (rxd),
        .rx_busy    (rx_busy),
        .rx_data    (rx_data),
        .rx_done    (rx_done),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_frame(input logic [7:0] d, input logic done, input logic ferr,
                                input logic perr);
        exp_t e;
        e.data = d;
        e.done = done;
        e.ferr = ferr;
        e.perr = perr;
        exp_q.push_back(e);
        if (done) n_good++;
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic bad_par);
        rxd = 1'b0;
        repeat (c_bit) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            repeat (c_bit) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rxd = (^d) ^ bad_par;
        repeat (c_bit) @(negedge clk);
`endif
        rxd = stop_v;
        repeat (c_bit) @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, 32'(rx_busy), 32'd0);
        check({tag, "_data"}, 32'(rx_data), 32'h00);
        check({tag, "_done"}, 32'(rx_done), 32'd0);
        check({tag, "_ferr"}, 32'(frame_err), 32'd0);
        check({tag, "_perr"}, 32'(parity_err), 32'd0);
    endtask

    // Monitor: every falling edge of rx_busy is one frame outcome.
    always @(negedge clk) begin
        if (rst) begin
            prev_busy = 1'b0;
            busy_len  = 0;
        end else begin
            if (rx_done) done_cnt++;
            if (rx_busy) busy_len++;
            if (prev_busy && !rx_busy) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("rx_data", 32'(rx_data), 32'(e.data));
                    check("rx_done", 32'(rx_done), 32'(e.done));
                    check("frame_err", 32'(frame_err), 32'(e.ferr));
                    check("parity_err", 32'(parity_err), 32'(e.perr));
                    check("busy_len", 32'(busy_len), 32'(c_busy_len));
                end
                busy_len = 0;
            end
            prev_busy = rx_busy;
        end
    end

    initial begin
        logic seen;
        logic [7:0] b96;
        n_checks = 0;
        n_errors = 0;
        n_good   = 0;
        done_cnt = 0;
        rst = 1'b1;
        rxd = 1'b1;
        repeat (4) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        idle(2 * c_bit);

        // Good frame
        expect_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b1, 1'b0);
        idle(2 * c_bit);

        // False start: 6-clock low glitch
        rxd = 1'b0;
        repeat (6) @(negedge clk);
        rxd  = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 3 * c_bit; i++) begin
            @(negedge clk);
            if (rx_busy) seen = 1'b1;
        end
        check("false_start_busy", 32'(seen), 32'd0);
        check("false_start_data", 32'(rx_data), 32'hA5);

        // Framing error, line held low, then recovery frame
        expect_frame(8'hA5, 1'b0, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b0);
        rxd = 1'b0;
        repeat (3 * c_bit) @(negedge clk);
        check("ferr_hold_busy", 32'(rx_busy), 32'd0);
        check("ferr_hold_flag", 32'(frame_err), 32'd1);
        idle(c_bit);
        expect_frame(8'h81, 1'b1, 1'b0, 1'b0);
        send_frame(8'h81, 1'b1, 1'b0);
        idle(2 * c_bit);

        // Back-to-back frames
        expect_frame(8'h00, 1'b1, 1'b0, 1'b0);
        expect_frame(8'hFF, 1'b1, 1'b0, 1'b0);
        expect_frame(8'h55, 1'b1, 1'b0, 1'b0);
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        send_frame(8'h55, 1'b1, 1'b0);
        idle(2 * c_bit);

        // Reset in the middle of bit 4 of 0x96
        b96 = 8'h96;
        rxd = 1'b0;
        repeat (c_bit) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rxd = b96[i];
            repeat (c_bit) @(negedge clk);
        end
        rxd = b96[4];
        repeat (c_bit / 2) @(negedge clk);
        check("pre_reset_busy", 32'(rx_busy), 32'd1);
        rst = 1'b1;
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values("mid_reset");
        rst = 1'b0;
        idle(2 * c_bit);
        expect_frame(8'h12, 1'b1, 1'b0, 1'b0);
        send_frame(8'h12, 1'b1, 1'b0);
        idle(2 * c_bit);

`ifdef UART_RX_PARITY_EN
        expect_frame(8'h07, 1'b1, 1'b0, 1'b0);
        send_frame(8'h07, 1'b1, 1'b0);
        idle(2 * c_bit);
        expect_frame(8'h07, 1'b0, 1'b0, 1'b1);
        send_frame(8'h07, 1'b1, 1'b1);
        idle(2 * c_bit);
`endif

        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("done_count", 32'(done_cnt), 32'(n_good));
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
